// File: rtl/mul_div_unit.sv
// HI/LO multiply-divide unit for the execute stage.
// MTHI/MTLO write immediately; the other ops compute their 64-bit result at
// accept, hold it in a pending register, and commit it after a fixed latency.
module mul_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mulEnable,
  input  logic [3:0]  mulCtrl,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic        cancel,
  input  logic        mulOutputSel,
  output logic        busy,
  output logic [31:0] result
);

  // op encodings shared with the decoder
  localparam logic [3:0] MT_DISABLED = 4'd0;
  localparam logic [3:0] MT_MULT     = 4'd1;
  localparam logic [3:0] MT_MULTU    = 4'd2;
  localparam logic [3:0] MT_DIV      = 4'd3;
  localparam logic [3:0] MT_DIVU     = 4'd4;
  localparam logic [3:0] MT_MADD     = 4'd5;
  localparam logic [3:0] MT_MADDU    = 4'd6;
  localparam logic [3:0] MT_MSUB     = 4'd7;
  localparam logic [3:0] MT_SET_HI   = 4'd8;
  localparam logic [3:0] MT_SET_LO   = 4'd9;

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  state_t        state;
  hilo_t         hilo, pend, calc;
  logic [CW-1:0] counter;
  logic          accept, is_mul, is_div, is_set;

  logic signed [63:0] a_s, b_s, sprod;
  logic        [63:0] uprod;
  logic               a_neg, b_neg, b_zero;
  logic        [31:0] a_mag, b_mag, b_div_u, b_div_s;
  logic        [31:0] uq, ur, sq_mag, sr_mag, sq, sr;

  assign accept = mulEnable & ~busy & ~cancel;

  // products: explicit extension keeps the full 64-bit result exact
  assign a_s   = {{32{operandA[31]}}, operandA};
  assign b_s   = {{32{operandB[31]}}, operandB};
  assign sprod = a_s * b_s;
  assign uprod = {32'd0, operandA} * {32'd0, operandB};

  // signed division on magnitudes; 0x80000000 is its own magnitude as unsigned,
  // so the INT_MIN / -1 case naturally yields LO=0x80000000, HI=0
  assign a_neg   = operandA[31];
  assign b_neg   = operandB[31];
  assign b_zero  = (operandB == 32'd0);
  assign a_mag   = a_neg ? (32'd0 - operandA) : operandA;
  assign b_mag   = b_neg ? (32'd0 - operandB) : operandB;
  // a zero divisor never reaches the dividers; its result is discarded anyway
  assign b_div_u = b_zero ? 32'd1 : operandB;
  assign b_div_s = b_zero ? 32'd1 : b_mag;
  assign uq      = operandA / b_div_u;
  assign ur      = operandA % b_div_u;
  assign sq_mag  = a_mag / b_div_s;
  assign sr_mag  = a_mag % b_div_s;
  assign sq      = (a_neg ^ b_neg) ? (32'd0 - sq_mag) : sq_mag;
  assign sr      = a_neg ? (32'd0 - sr_mag) : sr_mag;

  // decode op class and the value that would be committed for it
  always_comb begin
    calc   = hilo;
    is_mul = 1'b0;
    is_div = 1'b0;
    is_set = 1'b0;
    case (mulCtrl)
      MT_MULT:   begin is_mul = 1'b1; calc = sprod; end
      MT_MULTU:  begin is_mul = 1'b1; calc = uprod; end
      MT_MADD:   begin is_mul = 1'b1; calc = hilo + sprod; end
      MT_MADDU:  begin is_mul = 1'b1; calc = hilo + uprod; end
      MT_MSUB:   begin is_mul = 1'b1; calc = hilo - sprod; end
      // divide by zero commits the HI/LO seen at accept, i.e. no change
      MT_DIV:    begin is_div = 1'b1; if (!b_zero) calc = {sr, sq}; end
      MT_DIVU:   begin is_div = 1'b1; if (!b_zero) calc = {ur, uq}; end
      MT_SET_HI: is_set = 1'b1;
      MT_SET_LO: is_set = 1'b1;
      MT_DISABLED: calc = hilo;
      default:   calc = hilo;
    endcase
  end

  // IDLE/RUN control, architectural HI/LO and pending result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      hilo    <= '0;
      pend    <= '0;
      counter <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (mulCtrl == MT_SET_HI) hilo.hi <= operandA;
            if (mulCtrl == MT_SET_LO) hilo.lo <= operandA;
            if (is_mul || is_div) begin
              pend    <= calc;
              counter <= is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
              state   <= RUN;
              busy    <= 1'b1;
            end
          end
        end
        RUN: begin
          // cancel takes priority over a commit on the same edge
          if (cancel) begin
            state   <= IDLE;
            busy    <= 1'b0;
            counter <= '0;
          end else if (counter == CW'(1)) begin
            hilo    <= pend;
            state   <= IDLE;
            busy    <= 1'b0;
            counter <= '0;
          end else begin
            counter <= counter - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // only architectural HI/LO is visible; pending is never forwarded
  assign result = mulOutputSel ? hilo.hi : hilo.lo;

  // is_set is decoded for completeness of the op map; MTHI/MTLO act directly
  logic unused_ok;
  assign unused_ok = is_set;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized + directed bench for mul_div_unit against an arithmetic model.
module tb_mul_div_unit;

  localparam int MULC = 5;
  localparam int DIVC = 10;

  localparam logic [3:0] MT_DISABLED = 4'd0;
  localparam logic [3:0] MT_MULT     = 4'd1;
  localparam logic [3:0] MT_MULTU    = 4'd2;
  localparam logic [3:0] MT_DIV      = 4'd3;
  localparam logic [3:0] MT_DIVU     = 4'd4;
  localparam logic [3:0] MT_MADD     = 4'd5;
  localparam logic [3:0] MT_MADDU    = 4'd6;
  localparam logic [3:0] MT_MSUB     = 4'd7;
  localparam logic [3:0] MT_SET_HI   = 4'd8;
  localparam logic [3:0] MT_SET_LO   = 4'd9;

  logic        clk = 1'b0;
  logic        reset, mulEnable, cancel, mulOutputSel, busy;
  logic [3:0]  mulCtrl;
  logic [31:0] operandA, operandB, result;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  mul_div_unit #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .reset(reset), .mulEnable(mulEnable), .mulCtrl(mulCtrl),
    .operandA(operandA), .operandB(operandB), .cancel(cancel),
    .mulOutputSel(mulOutputSel), .busy(busy), .result(result)
  );

  // architectural effect of one op, straight from the instruction definitions
  function automatic logic [63:0] ref_op(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] hl);
    longint sa, sb, q, r;
    logic [63:0] sp, up;
    logic [31:0] uqv, urv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sp = sa * sb;
    up = {32'd0, a} * {32'd0, b};
    case (c)
      MT_MULT:   return sp;
      MT_MULTU:  return up;
      MT_MADD:   return hl + sp;
      MT_MADDU:  return hl + up;
      MT_MSUB:   return hl - sp;
      MT_DIV: begin
        if (b == 32'd0) return hl;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MT_DIVU: begin
        if (b == 32'd0) return hl;
        uqv = a / b;
        urv = a % b;
        return {urv, uqv};
      end
      MT_SET_HI: return {a, hl[31:0]};
      MT_SET_LO: return {hl[63:32], a};
      default:   return hl;
    endcase
  endfunction

  function automatic int ref_cycles(input logic [3:0] c);
    case (c)
      MT_MULT, MT_MULTU, MT_MADD, MT_MADDU, MT_MSUB: return MULC;
      MT_DIV, MT_DIVU: return DIVC;
      default: return 0;
    endcase
  endfunction

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    mulOutputSel = 1'b1;
    #1 h = result;
    mulOutputSel = 1'b0;
    #1 l = result;
  endtask

  // one-cycle start pulse; returns at the negedge of the first cycle after accept
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mulCtrl = c; operandA = a; operandB = b; mulEnable = 1'b1;
    @(negedge clk);
    mulEnable = 1'b0; mulCtrl = MT_DISABLED;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // issue one op, then compare busy length and the committed HI/LO with the model
  task automatic run_op(input string nm, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    logic [31:0] h, l;
    int n;
    exp = ref_op(c, a, b, {m_hi, m_lo});
    issue(c, a, b);
    wait_idle(n);
    read_hilo(h, l);
    checks++;
    if (n !== ref_cycles(c)) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d want %0d", nm, n, ref_cycles(c));
    end
    checks++;
    if (h !== exp[63:32]) begin
      errors++;
      $display("FAIL %s hi got %h want %h (a=%h b=%h)", nm, h, exp[63:32], a, b);
    end
    checks++;
    if (l !== exp[31:0]) begin
      errors++;
      $display("FAIL %s lo got %h want %h (a=%h b=%h)", nm, l, exp[31:0], a, b);
    end
    {m_hi, m_lo} = exp;
  endtask

  task automatic test_reset();
    logic [31:0] h, l;
    reset = 1'b0; mulEnable = 1'b0; cancel = 1'b0; mulOutputSel = 1'b0;
    mulCtrl = MT_DISABLED; operandA = '0; operandB = '0;
    #12;
    read_hilo(h, l);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (h !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", h); end
    checks++;
    if (l !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", l); end
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult();
    logic [3:0] c;
    run_op("mult_neg2x3", MT_MULT, 32'hFFFF_FFFE, 32'd3);
    checks++;
    if ({m_hi, m_lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      errors++; $display("FAIL mult_directed_model got %h want FFFFFFFFFFFFFFFA", {m_hi, m_lo});
    end
    run_op("multu_max", MT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      c = ($urandom_range(0, 1) == 0) ? MT_MULT : MT_MULTU;
      run_op("mult_rand", c, $urandom, $urandom);
    end
  endtask

  task automatic test_madd();
    logic [3:0] c;
    run_op("mthi", MT_SET_HI, 32'd1, 32'd0);
    run_op("mtlo", MT_SET_LO, 32'hFFFF_FFFF, 32'd0);
    run_op("maddu_carry", MT_MADDU, 32'd1, 32'd1);
    run_op("msub_borrow", MT_MSUB, 32'd1, 32'd1);
    for (int i = 0; i < 9; i++) begin
      case ($urandom_range(0, 2))
        0:       c = MT_MADD;
        1:       c = MT_MADDU;
        default: c = MT_MSUB;
      endcase
      run_op("madd_rand", c, $urandom, $urandom);
    end
  endtask

  task automatic test_div();
    logic [31:0] a, b;
    run_op("div_neg7_2", MT_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_by0", MT_DIVU, 32'd7, 32'd0);
    run_op("div_by0", MT_DIV, 32'h8000_0000, 32'd0);
    run_op("div_intmin_m1", MT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_7_neg2", MT_DIV, 32'd7, 32'hFFFF_FFFE);
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? 32'($signed($urandom_range(0, 40)) - 20) : $urandom;
      run_op("div_rand", ($urandom_range(0, 1) == 0) ? MT_DIV : MT_DIVU, a, b);
    end
  endtask

  // unknown / disabled codes and a start dropped by a same-cycle cancel
  task automatic test_noop();
    logic [31:0] h, l;
    run_op("disabled", MT_DISABLED, 32'h1234, 32'h5678);
    run_op("unknown", 4'd15, 32'h1234, 32'h5678);
    @(negedge clk);
    mulCtrl = MT_DIV; operandA = 32'd100; operandB = 32'd3; mulEnable = 1'b1; cancel = 1'b1;
    @(negedge clk);
    mulCtrl = MT_SET_HI; operandA = 32'hDEAD_BEEF;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL cancel_idle_busy got %b want 0", busy); end
    @(negedge clk);
    mulEnable = 1'b0; cancel = 1'b0; mulCtrl = MT_DISABLED;
    read_hilo(h, l);
    checks++;
    if ({h, l} !== {m_hi, m_lo}) begin
      errors++; $display("FAIL cancel_idle_hilo got %h want %h", {h, l}, {m_hi, m_lo});
    end
  endtask

  task automatic test_cancel();
    logic [31:0] h, l;
    run_op("pre_mthi", MT_SET_HI, 32'h1111_1111, 32'd0);
    run_op("pre_mtlo", MT_SET_LO, 32'h2222_2222, 32'd0);
    // cancel raised during busy cycle 4
    issue(MT_DIVU, 32'd1000, 32'd7);
    repeat (3) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL cancel_mid_busy got %b want 0", busy); end
    repeat (12) @(negedge clk);
    read_hilo(h, l);
    checks++;
    if ({h, l} !== {m_hi, m_lo}) begin
      errors++; $display("FAIL cancel_mid_hilo got %h want %h", {h, l}, {m_hi, m_lo});
    end
    // cancel on the commit edge (last busy cycle)
    issue(MT_DIVU, 32'd1000, 32'd7);
    repeat (DIVC - 1) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL cancel_commit_lastbusy got %b want 1", busy); end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL cancel_commit_busy got %b want 0", busy); end
    read_hilo(h, l);
    checks++;
    if ({h, l} !== {m_hi, m_lo}) begin
      errors++; $display("FAIL cancel_commit_hilo got %h want %h", {h, l}, {m_hi, m_lo});
    end
  endtask

  // a start while busy is ignored: one commit, no extra busy period
  task automatic test_back_to_back();
    logic [63:0] exp;
    logic [31:0] h, l;
    int n;
    exp = ref_op(MT_MULT, 32'd1234, 32'hFFFF_FF00, {m_hi, m_lo});
    issue(MT_MULT, 32'd1234, 32'hFFFF_FF00);
    mulCtrl = MT_MULTU; operandA = 32'd77; operandB = 32'd99; mulEnable = 1'b1;
    @(negedge clk);
    mulEnable = 1'b0; mulCtrl = MT_DISABLED;
    wait_idle(n);
    checks++;
    if (n !== MULC - 1) begin errors++; $display("FAIL b2b_busy_rest got %0d want %0d", n, MULC - 1); end
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_second got busy %b want 0", busy); end
    end
    read_hilo(h, l);
    checks++;
    if ({h, l} !== exp) begin errors++; $display("FAIL b2b_hilo got %h want %h", {h, l}, exp); end
    {m_hi, m_lo} = exp;
  endtask

  // asynchronous reset between edges while a divide is in flight
  task automatic test_reset_mid();
    logic [31:0] h, l;
    issue(MT_DIV, 32'hFFFF_FFF9, 32'd2);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got %b want 0", busy); end
    read_hilo(h, l);
    checks++;
    if ({h, l} !== 64'd0) begin errors++; $display("FAIL async_reset_hilo got %h want 0", {h, l}); end
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    run_op("after_reset", MT_MULTU, 32'd6, 32'd7);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_madd();
    test_div();
    test_noop();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
